// File: rtl/spi_pkg.sv
// Shared constants for the SPI responder: bus mode, default fill word,
// and FSM state encoding.
package spi_pkg;
    // Bus mode is fixed: clock idles low, data changes on the leading edge
    // and is sampled on the trailing edge.
    localparam logic       CPOL     = 1'b0;
    localparam logic       CPHA     = 1'b1;
    localparam int         DWIDTH_DEF = 8;
    localparam logic [7:0] FILL_DEF = 8'hFF;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, followed by one
// edge-detect flop that yields single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Shift the pin through the synchroniser and remember the last synced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  =  level & ~prev;
    assign fall  = ~level &  prev;
endmodule

// File: rtl/spi_slave_core.sv
// SPI responder: synchronises the bus pins into clk, shifts mosi into
// rx_data and shifts a host-loaded word (or the fill word) out on miso.
// Words repeat back-to-back while ss_n stays low.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int                DWIDTH      = DWIDTH_DEF,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DWIDTH-1:0] FILL        = DWIDTH'(FILL_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DWIDTH-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_abort
);
    localparam int CW = $clog2(DWIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DWIDTH - 1);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst(rst), .din(ss_n),
        .level(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    // mosi only needs its level; same depth as sclk so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) mosi_sync <= '0;
        else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Map the bus mode onto shift-out / sample edges (folds to constants).
    logic out_edge, in_edge;
    assign out_edge = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;
    assign in_edge  = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;

    spi_state_e        state;
    logic [CW-1:0]     bit_cnt;
    logic [DWIDTH-1:0] shreg_tx, shreg_rx, tx_buf;
    logic              tx_full, armed;
    // Set when a word-boundary reload had to use FILL; the underrun is
    // reported when that word actually starts shifting, so the reload
    // after the last word of a frame does not flag a spurious underrun.
    logic              fill_pend;
    logic              accept;

    assign accept   = tx_valid & ~tx_full;
    assign tx_ready = ~tx_full;

    // Frame FSM, bit counter, one-entry tx buffer and both shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shreg_tx    <= '0;
            shreg_rx    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            armed       <= 1'b0;
            fill_pend   <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
            // A reset mid-frame must not pick the frame up halfway through.
            if (ss_s) armed <= 1'b1;
            // Consume (needs full) and accept (needs empty) never coincide.
            if (accept) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (ss_fall && armed) begin
                        state     <= S_ACTIVE;
                        miso_oe   <= 1'b1;
                        bit_cnt   <= '0;
                        fill_pend <= 1'b0;
                        if (tx_full) begin
                            shreg_tx <= tx_buf;
                            tx_full  <= 1'b0;
                        end else begin
                            shreg_tx    <= FILL;
                            tx_underrun <= 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (ss_rise) begin
                        state     <= S_IDLE;
                        miso_oe   <= 1'b0;
                        miso      <= 1'b0;
                        bit_cnt   <= '0;
                        shreg_rx  <= '0;
                        fill_pend <= 1'b0;
                        if (bit_cnt != '0) frame_abort <= 1'b1;
                    end else if (out_edge) begin
                        miso     <= shreg_tx[DWIDTH-1];
                        shreg_tx <= {shreg_tx[DWIDTH-2:0], 1'b0};
                        if (fill_pend) begin
                            tx_underrun <= 1'b1;
                            fill_pend   <= 1'b0;
                        end
                    end else if (in_edge) begin
                        shreg_rx <= {shreg_rx[DWIDTH-2:0], mosi_s};
                        if (bit_cnt == LAST_BIT) begin
                            rx_data  <= {shreg_rx[DWIDTH-2:0], mosi_s};
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            if (tx_full) begin
                                shreg_tx <= tx_buf;
                                tx_full  <= 1'b0;
                            end else begin
                                shreg_tx  <= FILL;
                                fill_pend <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
